// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Read-mode constants and pointer-width helper for sync_fifo.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_if
// Purpose  : Producer/consumer handshake and status bundle for sync_fifo.
// Revision : 1.0 - initial release
// ============================================================================
interface sync_fifo_if #(
    parameter int WIDTH    = 8,
    parameter int PTRWIDTH = 3
);

    logic                w_en;
    logic [WIDTH-1:0]    data_in;
    logic                r_en;
    logic [WIDTH-1:0]    data_out;
    logic                full;
    logic                empty;
    logic                almost_full;
    logic                almost_empty;
    logic [PTRWIDTH:0]   count;
    logic                overflow;
    logic                underflow;

    modport master (
        output w_en, data_in, r_en,
        input  data_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  w_en, data_in, r_en,
        output data_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface
`default_nettype wire

// File: rtl/sync_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_ram
// Purpose  : DEPTH x WIDTH storage, synchronous write, asynchronous read.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_ram #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int AWIDTH = 3
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [AWIDTH-1:0] i_waddr,
    input  wire logic [WIDTH-1:0]  i_wdata,
    input  wire logic [AWIDTH-1:0] i_raddr,
    output logic      [WIDTH-1:0]  o_rdata
);

    // Contents are deliberately left unreset so this maps onto plain RAM.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with count, threshold flags, error pulses and
//            selectable standard / first-word-fall-through read mode.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int PTRWIDTH  = ptr_width(DEPTH),
    parameter int FWFT      = FIFO_MODE_STD,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  wire logic  clk,
    input  wire logic  rst,
    sync_fifo_if.slave bus
);

    localparam logic [PTRWIDTH:0] c_afull_th  = AFULL_TH[PTRWIDTH:0];
    localparam logic [PTRWIDTH:0] c_aempty_th = AEMPTY_TH[PTRWIDTH:0];

    logic [PTRWIDTH:0] r_wptr;
    logic [PTRWIDTH:0] r_rptr;
    logic [PTRWIDTH:0] w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              r_overflow;
    logic              r_underflow;
    logic [WIDTH-1:0]  w_rd_data;

    // The extra pointer MSB separates full from empty when the addresses match.
    assign w_count  = r_wptr - r_rptr;
    assign w_full   = (r_wptr[PTRWIDTH] != r_rptr[PTRWIDTH]) &&
                      (r_wptr[PTRWIDTH-1:0] == r_rptr[PTRWIDTH-1:0]);
    assign w_empty  = (r_wptr == r_rptr);
    assign w_wr_acc = bus.w_en && !w_full;
    assign w_rd_acc = bus.r_en && !w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_overflow  <= bus.w_en && w_full;
            r_underflow <= bus.r_en && w_empty;
        end
    end

    sync_fifo_ram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .AWIDTH (PTRWIDTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wptr[PTRWIDTH-1:0]),
        .i_wdata (bus.data_in),
        .i_raddr (r_rptr[PTRWIDTH-1:0]),
        .o_rdata (w_rd_data)
    );

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            // Head word shown straight from storage; forced to zero while empty.
            assign bus.data_out = w_empty ? '0 : w_rd_data;
        end else begin : g_std
            logic [WIDTH-1:0] r_data_out;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_data_out <= '0;
                end else if (w_rd_acc) begin
                    r_data_out <= w_rd_data;
                end
            end

            assign bus.data_out = r_data_out;
        end
    endgenerate

    assign bus.count        = w_count;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (w_count >= c_afull_th);
    assign bus.almost_empty = (w_count <= c_aempty_th);
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule
`default_nettype wire
